// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arb_pkg
//  Description : Shared state encoding and default sizes for adder_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESP  = 2'd1,
        CHECK = 2'd2
    } state_t;

endpackage : adder_arb_pkg
`default_nettype wire

// File: rtl/adder_arbiter_adder.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arbiter_adder
//  Description : Combinational WIDTH-bit adder with carry out in y[WIDTH].
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   y
);

    assign y = {1'b0, a} + {1'b0, b};

endmodule : adder_arbiter_adder
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arbiter
//  Description : Round-robin sharing of one adder among NUM_REQ requesters,
//                result returned on a tagged valid/ready response channel.
//                ADDER_ARB_FAULT_CHECK_EN adds a swapped-operand recheck cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int WIDTH   = DEF_WIDTH,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_y,
    output logic                     rsp_cout,
    output logic                     rsp_fault,
    output logic [7:0]               fault_cnt
);

    state_t            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              rsp_valid_q;

    logic              accept_ok;
    logic              accept;
    logic [ID_W:0]     pick;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic [WIDTH-1:0]  a_g;
    logic [WIDTH-1:0]  b_g;
    logic [WIDTH-1:0]  add_a;
    logic [WIDTH-1:0]  add_b;
    logic [WIDTH:0]    sum;

    // Scan from ptr+1 with wrap; iterating backwards leaves the nearest hit.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0]   r;
        logic [ID_W-1:0] idx;
        r = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (v[idx]) begin
                r = {1'b1, idx};
            end
        end
        return r;
    endfunction

    assign pick      = rr_pick(req_valid, rr_ptr_q);
    assign gnt_any   = pick[ID_W];
    assign gnt_idx   = pick[ID_W-1:0];
    assign accept_ok = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    assign accept    = accept_ok && gnt_any;
    assign a_g       = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    assign b_g       = req_b[int'(gnt_idx)*WIDTH +: WIDTH];

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

`ifdef ADDER_ARB_FAULT_CHECK_EN
    assign add_a = (state_q == CHECK) ? b_q : a_q;
    assign add_b = (state_q == CHECK) ? a_q : b_q;
`else
    assign add_a = a_q;
    assign add_b = b_q;
`endif

    adder_arbiter_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a (add_a),
        .b (add_b),
        .y (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            if (accept) begin
                a_q      <= a_g;
                b_q      <= b_g;
                id_q     <= gnt_idx;
                rr_ptr_q <= gnt_idx;
            end
            case (state_q)
                IDLE, RESP: begin
                    if (accept) begin
`ifdef ADDER_ARB_FAULT_CHECK_EN
                        state_q     <= CHECK;
                        rsp_valid_q <= 1'b0;
`else
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
`endif
                    end else if ((state_q == RESP) && rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
`ifdef ADDER_ARB_FAULT_CHECK_EN
                CHECK: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
`endif
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_y     = sum[WIDTH-1:0];
    assign rsp_cout  = sum[WIDTH];

`ifdef ADDER_ARB_FAULT_CHECK_EN
    logic [WIDTH:0] chk_q;
    logic           fresh_q;
    logic [7:0]     fault_cnt_q;
    logic [7:0]     fault_cnt_d;
    logic           mismatch;

    // The swapped sum captured in CHECK is compared with the live sum in RESP.
    assign mismatch = (sum != chk_q);

    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (fresh_q && rsp_valid_q && mismatch && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_d = fault_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q       <= '0;
            fresh_q     <= 1'b0;
            fault_cnt_q <= '0;
        end else begin
            fresh_q     <= (state_q == CHECK);
            fault_cnt_q <= fault_cnt_d;
            if (state_q == CHECK) begin
                chk_q <= sum;
            end
        end
    end

    assign rsp_fault = rsp_valid_q && mismatch;
    assign fault_cnt = fault_cnt_q;
`else
    assign rsp_fault = 1'b0;
    assign fault_cnt = 8'd0;
`endif

endmodule : adder_arbiter
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_arbiter
//  Description : Self-checking bench for adder_arbiter: vector table, corner
//                sequences and randomized traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [3:0]    req_valid = '0;
    logic [3:0]    req_ready;
    logic [127:0]  req_a = '0;
    logic [127:0]  req_b = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_y;
    logic          rsp_cout;
    logic          rsp_fault;
    logic [7:0]    fault_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_arbiter #(
        .NUM_REQ (4),
        .WIDTH   (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_cout  (rsp_cout),
        .rsp_fault (rsp_fault),
        .fault_cnt (fault_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        bit          rst;
        int          opset;
        logic [3:0]  rv;
        logic        rdy;
        logic [3:0]  exp_ready;
        logic        exp_v;
        logic [1:0]  exp_id;
        logic [31:0] exp_y;
        logic        exp_c;
    } vec_t;

    function automatic vec_t mk(bit rst, int opset, logic [3:0] rv, logic rdy,
                                logic [3:0] er, logic ev, logic [1:0] eid,
                                logic [31:0] ey, logic ec);
        vec_t v;
        v.rst = rst; v.opset = opset; v.rv = rv; v.rdy = rdy;
        v.exp_ready = er; v.exp_v = ev; v.exp_id = eid; v.exp_y = ey; v.exp_c = ec;
        return v;
    endfunction

    function automatic int rr_model(logic [3:0] v, int last);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    logic [3:0][31:0] set_a [2];
    logic [3:0][31:0] set_b [2];
    vec_t             tbl   [18];

`ifndef ADDER_ARB_FAULT_CHECK_EN
    initial begin
        bit          m_busy;
        int          m_last;
        logic [1:0]  m_id;
        logic [32:0] m_sum;
        logic [3:0][31:0] ra, rb;
        int          w;
        logic [3:0]  er;

        set_a[0] = {32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1};
        set_b[0] = {32'h0, 32'h0000_0001, 32'h0, 32'h1};
        set_a[1] = {32'h0000_0010, 32'h8000_0000, 32'hA5A5_A5A5, 32'h1234_5678};
        set_b[1] = {32'h0000_0020, 32'h8000_0000, 32'h5A5A_5A5A, 32'h8765_4321};

        tbl[0]  = mk(1, 0, 4'b0001, 1, 4'b0001, 0, 0, 32'h0, 0);
        tbl[1]  = mk(0, 0, 4'b0000, 1, 4'b0000, 1, 0, 32'h2, 0);
        tbl[2]  = mk(0, 0, 4'b0100, 1, 4'b0100, 0, 0, 32'h0, 0);
        tbl[3]  = mk(0, 0, 4'b0000, 1, 4'b0000, 1, 2, 32'h0, 1);
        tbl[4]  = mk(1, 1, 4'b1111, 1, 4'b0001, 0, 0, 32'h0, 0);
        tbl[5]  = mk(0, 1, 4'b1111, 1, 4'b0010, 1, 0, 32'h9999_9999, 0);
        tbl[6]  = mk(0, 1, 4'b1111, 1, 4'b0100, 1, 1, 32'hFFFF_FFFF, 0);
        tbl[7]  = mk(0, 1, 4'b1111, 1, 4'b1000, 1, 2, 32'h0000_0000, 1);
        tbl[8]  = mk(0, 1, 4'b1111, 1, 4'b0001, 1, 3, 32'h0000_0030, 0);
        tbl[9]  = mk(0, 1, 4'b0000, 0, 4'b0000, 1, 0, 32'h9999_9999, 0);
        for (int i = 10; i < 15; i++)
            tbl[i] = mk(0, 1, 4'b0011, 0, 4'b0000, 1, 0, 32'h9999_9999, 0);
        tbl[15] = mk(0, 1, 4'b0011, 1, 4'b0010, 1, 0, 32'h9999_9999, 0);
        tbl[16] = mk(0, 1, 4'b0000, 1, 4'b0000, 1, 1, 32'hFFFF_FFFF, 0);
        tbl[17] = mk(0, 1, 4'b0000, 1, 4'b0000, 0, 0, 32'h0, 0);

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_id",    rsp_id,    2'd0);
        chk("reset_rsp_y",     rsp_y,     32'h0);
        chk("reset_rsp_cout",  rsp_cout,  1'b0);
        chk("reset_rsp_fault", rsp_fault, 1'b0);
        chk("reset_fault_cnt", fault_cnt, 8'd0);
        chk("reset_req_ready", req_ready, 4'b0000);
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].rst) do_reset();
            req_valid = tbl[i].rv;
            rsp_ready = tbl[i].rdy;
            req_a     = set_a[tbl[i].opset];
            req_b     = set_b[tbl[i].opset];
            @(negedge clk);
            chk($sformatf("row%0d_req_ready", i), req_ready, tbl[i].exp_ready);
            chk($sformatf("row%0d_rsp_valid", i), rsp_valid, tbl[i].exp_v);
            if (tbl[i].exp_v) begin
                chk($sformatf("row%0d_rsp_id", i),   rsp_id,   tbl[i].exp_id);
                chk($sformatf("row%0d_rsp_y", i),    rsp_y,    tbl[i].exp_y);
                chk($sformatf("row%0d_rsp_cout", i), rsp_cout, tbl[i].exp_c);
            end
            @(posedge clk); #1;
        end

        // Reset while a result is pending, then first grant must go to 0
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("midrst_accept", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("midrst_pending", rsp_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk("midrst_async_drop", rsp_valid, 1'b0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("midrst_first_grant", req_ready, 4'b0001);
        chk("midrst_no_rsp", rsp_valid, 1'b0);

        // Randomized traffic against a transaction-level model
        do_reset();
        m_busy = 0;
        m_last = 3;
        m_id   = '0;
        m_sum  = '0;
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 4; r++) begin
                ra[r] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                rb[r] = $urandom;
            end
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_a     = ra;
            req_b     = rb;
            w  = (!m_busy || rsp_ready) ? rr_model(req_valid, m_last) : -1;
            er = (w >= 0) ? 4'(1 << w) : 4'b0000;
            @(negedge clk);
            chk($sformatf("rnd%0d_req_ready", c), req_ready, er);
            chk($sformatf("rnd%0d_rsp_valid", c), rsp_valid, m_busy);
            if (m_busy) begin
                chk($sformatf("rnd%0d_rsp_id", c), rsp_id, m_id);
                chk($sformatf("rnd%0d_rsp_sum", c), {rsp_cout, rsp_y}, m_sum);
            end
            chk($sformatf("rnd%0d_fault", c), {rsp_fault, fault_cnt}, 9'd0);
            @(posedge clk);
            if (w >= 0) begin
                m_busy = 1;
                m_id   = 2'(w);
                m_sum  = 33'(ra[w]) + 33'(rb[w]);
                m_last = w;
            end else if (m_busy && rsp_ready) begin
                m_busy = 0;
            end
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
`else
    initial begin
        do_reset();
        @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_fault_cnt", fault_cnt, 8'd0);
        @(posedge clk); #1;
        for (int pass = 0; pass < 2; pass++) begin
            req_valid = 4'b0001;
            rsp_ready = 1'b1;
            req_a     = {96'h0, 32'h0000_FFFF};
            req_b     = {96'h0, 32'hFFFF_0000};
            @(negedge clk);
            chk($sformatf("p%0d_accept", pass), req_ready, 4'b0001);
            @(posedge clk); #1;
            if (pass == 1) force dut.sum = 33'h0;
            req_valid = 4'b0010;
            @(negedge clk);
            chk($sformatf("p%0d_check_no_ready", pass), req_ready, 4'b0000);
            chk($sformatf("p%0d_check_no_valid", pass), rsp_valid, 1'b0);
            @(posedge clk); #1;
            release dut.sum;
            req_valid = 4'b0000;
            @(negedge clk);
            chk($sformatf("p%0d_rsp_valid", pass), rsp_valid, 1'b1);
            chk($sformatf("p%0d_rsp_y", pass), rsp_y, 32'hFFFF_FFFF);
            chk($sformatf("p%0d_rsp_fault", pass), rsp_fault, 1'(pass));
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("p%0d_fault_cnt", pass), fault_cnt, 8'(pass));
            chk($sformatf("p%0d_idle", pass), rsp_valid, 1'b0);
            @(posedge clk); #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
`endif

endmodule : tb_adder_arbiter
`default_nettype wire
